ledpanel_wr_sched: RTL and testbench
====================================

Name: ledpanel_wr_sched

Overview:
- Schedules the single write port of the LED panel framebuffer (wr_enable / wr_addr_x / wr_addr_y / wr_rgb_data) between two requesters.
- Requester 1 is the CPU pixel path: one pixel per request, mem_valid/mem_ready-style handshake.
- Requester 2 is a built-in rectangle-fill engine: it writes one colour over an (x0,y0)-(x1,y1) region, one pixel per granted cycle.
- Sits between the CPU memory/IO decoder and ledpanel.

Parameters:
- XW, 5, x-address width (panel width = 2**XW)
- YW, 5, y-address width
- RGBW, 24, colour data width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- px_valid  in  1  pixel write request; held until px_ready
- px_ready  out  1  one-cycle acceptance pulse
- px_x  in  XW  pixel x
- px_y  in  YW  pixel y
- px_rgb  in  RGBW  pixel colour
- fill_start  in  1  start fill (single-cycle pulse)
- fill_x0  in  XW  corner 0 x
- fill_y0  in  YW  corner 0 y
- fill_x1  in  XW  corner 1 x
- fill_y1  in  YW  corner 1 y
- fill_rgb  in  RGBW  fill colour
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle pulse with last fill pixel
- wr_enable  out  1  panel write strobe
- wr_addr_x  out  XW  panel write x
- wr_addr_y  out  YW  panel write y
- wr_rgb_data  out  RGBW  panel write data

Behaviour:
- Reset values (async, immediate): all outputs 0; state IDLE; last_grant=FILL; internal counters and latches 0.
- All outputs are registered. wr_enable is high for exactly one cycle per pixel written; at most one pixel is written per cycle.
- Pixel request pending = px_valid && !px_ready. This guard lets the requester drop or renew px_valid in the cycle after px_ready.
- State IDLE:
  - A pending pixel request is granted at the sampling edge.
  - After that edge: wr_enable=1, wr_addr_x/wr_addr_y/wr_rgb_data = px_x/px_y/px_rgb, px_ready=1 (1-cycle latency).
- fill_start sampled in IDLE:
  - Latch xmin=min(x0,x1), xmax=max(x0,x1), ymin=min(y0,y1), ymax=max(y0,y1), and fill_rgb.
  - Set cx=xmin, cy=ymin; go to FILL; fill_busy=1 after the same edge.
  - The first fill pixel appears on the following edge (2-cycle latency from fill_start).
- fill_start and px_valid in the same IDLE cycle: both take effect. The pixel is written at that edge and the fill is latched.
- State FILL, per edge:
  - Only fill pending: fill granted.
  - Both pending: round-robin. The requester not named by last_grant wins; last_grant updates on every grant.
  - Under contention each side therefore gets every other slot; neither is starved.
- Fill grant:
  - Emit (cx, cy, fill_rgb).
  - If cx==xmax: cx<=xmin, cy<=cy+1. Otherwise cx<=cx+1.
  - If cx==xmax && cy==ymax, this is the last pixel: fill_done=1 with that wr_enable, fill_busy<=0 on the same edge, state<=IDLE.
- Pixel count = (xmax-xmin+1)*(ymax-ymin+1). Range 1 (x0==x1, y0==y1) to 2**(XW+YW) (full panel, 1024 cycles uncontended).
- Scan order: row-major, increasing x, then increasing y.
- Counter arithmetic never wraps past xmax/ymax. The full-panel case (xmax = 2**XW-1) must terminate correctly with no overflow ambiguity: use the equality compare, not a compare on an incremented value.
- fill_start while fill_busy: ignored. No re-latch; the current fill is unaffected.
- Fill inputs are sampled only on the accepted fill_start edge; later changes are ignored.
- Reset asserted mid-fill or mid-pixel: all outputs go to 0 immediately; the fill is abandoned with no fill_done; the pending pixel is not acknowledged.
- Pixel writes and fill writes to the same address are written in grant order; the later grant wins in the framebuffer.

Test Plan:
- Single pixel: px_valid with (3,7,0x123456) in IDLE -> next cycle wr_enable=1, addr (3,7), data 0x123456, px_ready=1 for exactly 1 cycle. No second write while px_valid is still high during px_ready.
- Fill with swapped corners: fill_start with x0=5, x1=2, y0=1, y1=0, rgb=0xFF0000 -> 8 writes, order (2,0)(3,0)(4,0)(5,0)(2,1)(3,1)(4,1)(5,1). First write 2 cycles after start; fill_done with (5,1); fill_busy low afterwards.
- Contention: 3x1 fill plus continuous pixel requests from its first write -> writes alternate fill/pixel/fill/pixel/fill. fill_done on the 5th write; no starvation.
- Degenerate and full fills: x0=x1=9, y0=y1=4 -> exactly 1 write with fill_done in the same cycle. Full panel 0..31 x 0..31 -> exactly 1024 consecutive writes, last (31,31), then IDLE.
- Reset mid-fill and start while busy: assert reset after the 10th write of a full-panel fill -> outputs 0 immediately, no fill_done, a new fill runs normally after reset. fill_start while busy -> ignored; the original rectangle completes unchanged.

Source files
------------

// File: rtl/ledpanel_wr_sched.sv
// Arbitrates the panel write port between CPU pixel writes and a rectangle-fill engine; all outputs registered.
// Pixel: 1-cycle latency, px_ready pulse. Fill: first pixel 2 cycles after fill_start. Contention is round-robin.
module ledpanel_wr_sched #(
   parameter int XW   = 5,
   parameter int YW   = 5,
   parameter int RGBW = 24
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            px_valid,
   output logic            px_ready,
   input  logic [XW-1:0]   px_x,
   input  logic [YW-1:0]   px_y,
   input  logic [RGBW-1:0] px_rgb,
   input  logic            fill_start,
   input  logic [XW-1:0]   fill_x0,
   input  logic [YW-1:0]   fill_y0,
   input  logic [XW-1:0]   fill_x1,
   input  logic [YW-1:0]   fill_y1,
   input  logic [RGBW-1:0] fill_rgb,
   output logic            fill_busy,
   output logic            fill_done,
   output logic            wr_enable,
   output logic [XW-1:0]   wr_addr_x,
   output logic [YW-1:0]   wr_addr_y,
   output logic [RGBW-1:0] wr_rgb_data
);

   typedef enum logic {S_IDLE, S_FILL} state_t;
   typedef enum logic {G_PIX, G_FILL} grant_t;

   state_t          state_q;
   grant_t          last_grant_q;
   logic [XW-1:0]   xmin_q, xmax_q, cx_q;
   logic [YW-1:0]   ymin_q, ymax_q, cy_q;
   logic [RGBW-1:0] fill_rgb_q;
   logic            px_ready_q, fill_busy_q, fill_done_q, wr_enable_q;
   logic [XW-1:0]   wr_x_q;
   logic [YW-1:0]   wr_y_q;
   logic [RGBW-1:0] wr_rgb_q;

   logic            px_pend, px_win, row_end, fill_last;
   logic [XW-1:0]   x_lo, x_hi;
   logic [YW-1:0]   y_lo, y_hi;

   // px_ready still high means this request was taken last edge; don't take it twice
   assign px_pend   = px_valid && !px_ready_q;
   assign px_win    = px_pend && ((state_q == S_IDLE) || (last_grant_q == G_FILL));
   assign row_end   = (cx_q == xmax_q);
   assign fill_last = row_end && (cy_q == ymax_q);

   assign x_lo = (fill_x0 < fill_x1) ? fill_x0 : fill_x1;
   assign x_hi = (fill_x0 < fill_x1) ? fill_x1 : fill_x0;
   assign y_lo = (fill_y0 < fill_y1) ? fill_y0 : fill_y1;
   assign y_hi = (fill_y0 < fill_y1) ? fill_y1 : fill_y0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= G_FILL;
         xmin_q       <= '0;
         xmax_q       <= '0;
         cx_q         <= '0;
         ymin_q       <= '0;
         ymax_q       <= '0;
         cy_q         <= '0;
         fill_rgb_q   <= '0;
         px_ready_q   <= 1'b0;
         fill_busy_q  <= 1'b0;
         fill_done_q  <= 1'b0;
         wr_enable_q  <= 1'b0;
         wr_x_q       <= '0;
         wr_y_q       <= '0;
         wr_rgb_q     <= '0;
      end else begin
         wr_enable_q <= 1'b0;
         px_ready_q  <= 1'b0;
         fill_done_q <= 1'b0;

         if (px_win) begin
            wr_enable_q  <= 1'b1;
            wr_x_q       <= px_x;
            wr_y_q       <= px_y;
            wr_rgb_q     <= px_rgb;
            px_ready_q   <= 1'b1;
            last_grant_q <= G_PIX;
         end

         if (state_q == S_IDLE) begin
            if (fill_start) begin
               xmin_q      <= x_lo;
               xmax_q      <= x_hi;
               ymin_q      <= y_lo;
               ymax_q      <= y_hi;
               cx_q        <= x_lo;
               cy_q        <= y_lo;
               fill_rgb_q  <= fill_rgb;
               fill_busy_q <= 1'b1;
               state_q     <= S_FILL;
            end
         end else if (!px_win) begin
            wr_enable_q  <= 1'b1;
            wr_x_q       <= cx_q;
            wr_y_q       <= cy_q;
            wr_rgb_q     <= fill_rgb_q;
            last_grant_q <= G_FILL;
            // equality compares only, so a full-width rectangle ends without counter overflow
            if (fill_last) begin
               fill_done_q <= 1'b1;
               fill_busy_q <= 1'b0;
               state_q     <= S_IDLE;
            end else if (row_end) begin
               cx_q <= xmin_q;
               cy_q <= cy_q + YW'(1);
            end else begin
               cx_q <= cx_q + XW'(1);
            end
         end
      end
   end

   assign px_ready    = px_ready_q;
   assign fill_busy   = fill_busy_q;
   assign fill_done   = fill_done_q;
   assign wr_enable   = wr_enable_q;
   assign wr_addr_x   = wr_x_q;
   assign wr_addr_y   = wr_y_q;
   assign wr_rgb_data = wr_rgb_q;

endmodule

// File: tb/tb_ledpanel_wr_sched.sv
// Directed bench for ledpanel_wr_sched: expected writes are queued by the stimulus and checked by a negedge monitor.
module tb_ledpanel_wr_sched;

   logic        clk, reset;
   logic        px_valid, px_ready;
   logic [4:0]  px_x, px_y;
   logic [23:0] px_rgb;
   logic        fill_start, fill_busy, fill_done;
   logic [4:0]  fill_x0, fill_y0, fill_x1, fill_y1;
   logic [23:0] fill_rgb;
   logic        wr_enable;
   logic [4:0]  wr_addr_x, wr_addr_y;
   logic [23:0] wr_rgb_data;

   typedef struct {
      logic [4:0]  x;
      logic [4:0]  y;
      logic [23:0] rgb;
      logic        rdy;
      logic        done;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   ledpanel_wr_sched #(.XW(5), .YW(5), .RGBW(24)) dut (
      .clk(clk), .reset(reset),
      .px_valid(px_valid), .px_ready(px_ready),
      .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
      .fill_start(fill_start),
      .fill_x0(fill_x0), .fill_y0(fill_y0), .fill_x1(fill_x1), .fill_y1(fill_y1),
      .fill_rgb(fill_rgb), .fill_busy(fill_busy), .fill_done(fill_done),
      .wr_enable(wr_enable), .wr_addr_x(wr_addr_x), .wr_addr_y(wr_addr_y),
      .wr_rgb_data(wr_rgb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // monitor: every write must match the head of the scoreboard
   always @(negedge clk) begin
      if (!reset) begin
         if (wr_enable) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_write: got (%0d,%0d,%h) rdy=%b done=%b, required no write",
                        wr_addr_x, wr_addr_y, wr_rgb_data, px_ready, fill_done);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               if (wr_addr_x !== e.x || wr_addr_y !== e.y || wr_rgb_data !== e.rgb ||
                   px_ready !== e.rdy || fill_done !== e.done) begin
                  n_fail++;
                  $display("FAIL write: got (%0d,%0d,%h) rdy=%b done=%b, required (%0d,%0d,%h) rdy=%b done=%b",
                           wr_addr_x, wr_addr_y, wr_rgb_data, px_ready, fill_done,
                           e.x, e.y, e.rgb, e.rdy, e.done);
               end
            end
         end else if (px_ready || fill_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_without_write: got rdy=%b done=%b, required 0 0", px_ready, fill_done);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic push(input logic [4:0] x, input logic [4:0] y, input logic [23:0] rgb,
                       input logic rdy, input logic done);
      exp_t e;
      e.x = x; e.y = y; e.rgb = rgb; e.rdy = rdy; e.done = done;
      exp_q.push_back(e);
   endtask

   task automatic push_fill(input int xlo, input int xhi, input int ylo, input int yhi,
                            input logic [23:0] rgb);
      for (int y = ylo; y <= yhi; y++)
         for (int x = xlo; x <= xhi; x++)
            push(5'(x), 5'(y), rgb, 1'b0, (x == xhi && y == yhi));
   endtask

   task automatic fill_cmd(input logic [4:0] x0, input logic [4:0] y0, input logic [4:0] x1,
                           input logic [4:0] y1, input logic [23:0] rgb);
      fill_start = 1'b1;
      fill_x0 = x0; fill_y0 = y0; fill_x1 = x1; fill_y1 = y1; fill_rgb = rgb;
   endtask

   task automatic drain(input string name, input int budget);
      int used;
      used = 0;
      while (exp_q.size() != 0 && used < budget) begin
         tick();
         used++;
      end
      check(name, exp_q.size(), 0);
      repeat (3) tick();
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {wr_enable, px_ready, fill_busy, fill_done, wr_addr_x, wr_addr_y, wr_rgb_data}, 0);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      px_valid = 1'b0; px_x = '0; px_y = '0; px_rgb = '0;
      fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_x1 = '0; fill_y1 = '0; fill_rgb = '0;
      #1;
      check_outputs_zero("reset_state");
      tick();
      tick();
      reset = 1'b0;
      tick();

      // single pixel, held through its px_ready cycle
      push(5'd3, 5'd7, 24'h123456, 1'b1, 1'b0);
      px_valid = 1'b1; px_x = 5'd3; px_y = 5'd7; px_rgb = 24'h123456;
      tick();
      check("px_ready_pulse", px_ready, 1);
      tick();
      check("px_ready_single", {px_ready, wr_enable}, 0);
      px_valid = 1'b0;
      drain("pixel_drain", 5);

      // swapped corners; inputs scrambled after the start edge
      push_fill(2, 5, 0, 1, 24'hFF0000);
      fill_cmd(5'd5, 5'd1, 5'd2, 5'd0, 24'hFF0000);
      tick();
      fill_start = 1'b0;
      fill_x0 = 5'd30; fill_y0 = 5'd30; fill_x1 = 5'd31; fill_y1 = 5'd31; fill_rgb = 24'h00FFFF;
      check("fill_busy_set", fill_busy, 1);
      check("fill_latency_gap", wr_enable, 0);
      tick();
      check("fill_first_write", wr_enable, 1);
      drain("swap_drain", 20);
      check("swap_busy_clear", fill_busy, 0);

      // contention: fill 3x1 with pixel requests from the first fill write
      push(5'd0, 5'd10, 24'h00AA55, 1'b0, 1'b0);
      push(5'd20, 5'd3, 24'h111111, 1'b1, 1'b0);
      push(5'd1, 5'd10, 24'h00AA55, 1'b0, 1'b0);
      push(5'd21, 5'd4, 24'h222222, 1'b1, 1'b0);
      push(5'd2, 5'd10, 24'h00AA55, 1'b0, 1'b1);
      fill_cmd(5'd0, 5'd10, 5'd2, 5'd10, 24'h00AA55);
      tick();
      fill_start = 1'b0;
      tick();
      px_valid = 1'b1; px_x = 5'd20; px_y = 5'd3; px_rgb = 24'h111111;
      tick();
      px_x = 5'd21; px_y = 5'd4; px_rgb = 24'h222222;
      tick();
      tick();
      px_valid = 1'b0;
      drain("contend_drain", 10);
      check("contend_busy_clear", fill_busy, 0);

      // degenerate 1x1 fill issued together with a pixel
      push(5'd1, 5'd1, 24'hABCDEF, 1'b1, 1'b0);
      push(5'd9, 5'd4, 24'h0000FF, 1'b0, 1'b1);
      px_valid = 1'b1; px_x = 5'd1; px_y = 5'd1; px_rgb = 24'hABCDEF;
      fill_cmd(5'd9, 5'd4, 5'd9, 5'd4, 24'h0000FF);
      tick();
      check("simul_px_ready", px_ready, 1);
      check("simul_busy", fill_busy, 1);
      px_valid = 1'b0;
      fill_start = 1'b0;
      tick();
      check("degen_done", {wr_enable, fill_done, fill_busy}, 3'b110);
      drain("degen_drain", 5);

      // full panel, with a second fill_start while busy that must be ignored
      push_fill(0, 31, 0, 31, 24'h0F0F0F);
      fill_cmd(5'd31, 5'd0, 5'd0, 5'd31, 24'h0F0F0F);
      n = 0;
      while (exp_q.size() != 0 && n < 1200) begin
         tick();
         n++;
         if (n == 5) fill_cmd(5'd0, 5'd0, 5'd3, 5'd3, 24'hDEAD00);
         else fill_start = 1'b0;
      end
      check("full_cycles", n, 1025);
      tick();
      check("full_idle", {fill_busy, wr_enable}, 0);
      drain("full_drain", 5);

      // reset after the 10th write of a full-panel fill
      for (int i = 0; i < 10; i++) push(5'(i), 5'd0, 24'h5A5A5A, 1'b0, 1'b0);
      fill_cmd(5'd0, 5'd0, 5'd31, 5'd31, 24'h5A5A5A);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         tick();
         n++;
         fill_start = 1'b0;
      end
      check("reset_at_10th", n, 11);
      reset = 1'b1;
      px_valid = 1'b1; px_x = 5'd7; px_y = 5'd7; px_rgb = 24'h777777;
      #1;
      check_outputs_zero("reset_mid_fill");
      tick();
      tick();
      check_outputs_zero("reset_held");
      reset = 1'b0;
      px_valid = 1'b0;
      tick();
      check("post_reset_idle", {wr_enable, fill_busy, px_ready}, 0);
      push_fill(30, 31, 30, 31, 24'h00C0DE);
      fill_cmd(5'd31, 5'd31, 5'd30, 5'd30, 24'h00C0DE);
      tick();
      fill_start = 1'b0;
      drain("post_reset_fill", 10);
      check("post_reset_busy", fill_busy, 0);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
